// File: rtl/uart_pkg.sv
// Shared types for the UART transmit path: launch FSM states and byte width.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
    } uart_tx_fifo_state_e;

endpackage

// File: rtl/sync_fifo_mem.sv
// Simple dual-port storage array: one clocked write port, one combinational read port.
module sync_fifo_mem #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // No reset: stale entries are unreachable once the pointers are cleared.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO and launch controller feeding the UART transmitter.
// Optional sticky overflow flag when UART_TX_FIFO_OVF_EN is defined.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = UART_DATA_W
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_wr_valid,
    input  logic [DATA_W-1:0]        i_wr_data,
    output logic                     o_wr_ready,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_empty,
    input  logic                     i_uart_busy,
    output logic                     o_tx_en,
    output logic [DATA_W-1:0]        o_tx_data
`ifdef UART_TX_FIFO_OVF_EN
    ,
    input  logic                     i_ovf_clr,
    output logic                     o_ovf
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_ONE  = LW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: DEPTH must be a power of two >= 2");
    end

    uart_tx_fifo_state_e state;
    uart_tx_fifo_state_e state_nxt;

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [LW-1:0]     count;
    logic              full;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] head;
    logic              tx_en;
    logic [DATA_W-1:0] tx_data;

    assign full       = (count == FULL_LVL);
    assign o_wr_ready = !full;
    assign o_level    = count;
    assign o_empty    = (count == '0);
    assign o_tx_en    = tx_en;
    assign o_tx_data  = tx_data;

    // Full blocks writes even when a pop frees a slot in the same cycle.
    assign push = i_wr_valid && !full;

    sync_fifo_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_mem (
        .clk     (i_clk),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (i_wr_data),
        .rd_addr (rd_ptr),
        .rd_data (head)
    );

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        unique case (state)
            IDLE: begin
                if (!o_empty && !i_uart_busy) begin
                    pop       = 1'b1;
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                state_nxt = WAIT_BUSY;
            end
            // Transmitter raises busy one cycle after the strobe.
            WAIT_BUSY: begin
                if (i_uart_busy) begin
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!i_uart_busy) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                count <= count + LVL_ONE;
            end else if (pop && !push) begin
                count <= count - LVL_ONE;
            end
        end
    end

    // Strobe is high exactly for the LAUNCH cycle; data holds between launches.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tx_en   <= 1'b0;
            tx_data <= '0;
        end else begin
            tx_en <= pop;
            if (pop) begin
                tx_data <= head;
            end
        end
    end

`ifdef UART_TX_FIFO_OVF_EN
    logic ovf;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ovf <= 1'b0;
        end else if (i_wr_valid && full) begin
            ovf <= 1'b1;
        end else if (i_ovf_clr) begin
            ovf <= 1'b0;
        end
    end

    assign o_ovf = ovf;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: vector table plus multi-cycle sequences.
module tb_uart_tx_fifo;

    logic       clk;
    logic       rst_n;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic [4:0] level;
    logic       empty;
    logic       busy;
    logic       tx_en;
    logic [7:0] tx_data;
`ifdef UART_TX_FIFO_OVF_EN
    logic       ovf_clr;
    logic       ovf;
`endif

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] wq[$];

    typedef struct {
        logic       wr;
        logic [7:0] d;
        logic       bsy;
        logic       en;
        logic [7:0] q;
        logic [4:0] lvl;
    } vec_t;

    vec_t tv[23];

    uart_tx_fifo #(
        .DEPTH  (16),
        .DATA_W (8)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_wr_valid  (wr_valid),
        .i_wr_data   (wr_data),
        .o_wr_ready  (wr_ready),
        .o_level     (level),
        .o_empty     (empty),
        .i_uart_busy (busy),
        .o_tx_en     (tx_en),
        .o_tx_data   (tx_data)
`ifdef UART_TX_FIFO_OVF_EN
        ,
        .i_ovf_clr   (ovf_clr),
        .o_ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Transmitter model: busy rises 1 cycle after tx_en and lasts 10 cycles.
    // Bytes in wq are written one per cycle while the model runs.
    task automatic run_tx(input int n, input int max_cyc);
        int   got   = 0;
        int   viol  = 0;
        int   cyc   = 0;
        int   cnt   = 0;
        int   extra = 0;
        bit   pend  = 1'b0;
        logic prev_busy;
        logic prev_en = 1'b0;
        busy = 1'b0;
        while ((got < n || busy || pend || wq.size() > 0) && cyc < max_cyc) begin
            if (wq.size() > 0) begin
                wr_valid = 1'b1;
                wr_data  = wq.pop_front();
            end else begin
                wr_valid = 1'b0;
                wr_data  = 8'h00;
            end
            prev_busy = busy;
            step();
            cyc++;
            if (tx_en) begin
                if (prev_busy || prev_en) viol++;
                got++;
                if (exp_q.size() > 0) begin
                    chk("tx_data_order", 32'(tx_data), 32'(exp_q.pop_front()));
                end
                pend = 1'b1;
            end else if (pend) begin
                busy = 1'b1;
                cnt  = 10;
                pend = 1'b0;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) busy = 1'b0;
            end
            prev_en = tx_en;
        end
        wr_valid = 1'b0;
        chk("tx_within_budget", 32'(cyc < max_cyc), 32'd1);
        chk("tx_launch_count", 32'(got), 32'(n));
        chk("tx_launch_while_busy", 32'(viol), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            if (tx_en) extra++;
        end
        chk("tx_no_extra_launch", 32'(extra), 32'd0);
    endtask

    initial begin
        tv[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 5'd1};
        tv[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 5'd0};
        tv[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 5'd0};
        tv[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 5'd0};
        tv[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 5'd0};
        tv[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 5'd0};
        tv[6]  = '{1'b1, 8'h3C, 1'b1, 1'b0, 8'hA5, 5'd1};
        tv[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 5'd1};
        tv[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 5'd1};
        tv[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h3C, 5'd0};
        tv[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h3C, 5'd0};
        tv[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h3C, 5'd0};
        tv[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h3C, 5'd0};
        tv[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h3C, 5'd0};
        tv[14] = '{1'b1, 8'h77, 1'b0, 1'b0, 8'h3C, 5'd1};
        tv[15] = '{1'b1, 8'h88, 1'b0, 1'b1, 8'h77, 5'd1};
        tv[16] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h77, 5'd1};
        tv[17] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h77, 5'd1};
        tv[18] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h77, 5'd1};
        tv[19] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h88, 5'd0};
        tv[20] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h88, 5'd0};
        tv[21] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h88, 5'd0};
        tv[22] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h88, 5'd0};

        rst_n    = 1'b0;
        wr_valid = 1'b0;
        wr_data  = 8'h00;
        busy     = 1'b0;
`ifdef UART_TX_FIFO_OVF_EN
        ovf_clr  = 1'b0;
`endif
        #23;
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        chk("rst_tx_en", 32'(tx_en), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
`ifdef UART_TX_FIFO_OVF_EN
        chk("rst_ovf", 32'(ovf), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Single byte latency, busy-held IDLE, push/pop while launching.
        for (int i = 0; i < 23; i++) begin
            wr_valid = tv[i].wr;
            wr_data  = tv[i].d;
            busy     = tv[i].bsy;
            step();
            chk($sformatf("vec%0d_tx_en", i), 32'(tx_en), 32'(tv[i].en));
            chk($sformatf("vec%0d_tx_data", i), 32'(tx_data), 32'(tv[i].q));
            chk($sformatf("vec%0d_level", i), 32'(level), 32'(tv[i].lvl));
            chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(tv[i].lvl == 5'd0));
            chk($sformatf("vec%0d_wr_ready", i), 32'(wr_ready), 32'd1);
        end
        wr_valid = 1'b0;
        busy     = 1'b0;

        // Burst of four bytes against the transmitter model.
        for (int i = 1; i <= 4; i++) begin
            wq.push_back(8'(i));
            exp_q.push_back(8'(i));
        end
        run_tx(4, 200);
        chk("burst_empty", 32'(empty), 32'd1);

        // Seventeen writes with busy held: fill to 16, drop the 17th.
        busy = 1'b1;
        for (int i = 0; i < 17; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(8'h10 + i);
            if (i < 16) exp_q.push_back(8'(8'h10 + i));
            step();
            chk($sformatf("fill%0d_level", i), 32'(level), 32'(i < 16 ? i + 1 : 16));
            chk($sformatf("fill%0d_ready", i), 32'(wr_ready), 32'(i + 1 < 16));
`ifdef UART_TX_FIFO_OVF_EN
            if (i == 15) chk("ovf_before_drop", 32'(ovf), 32'd0);
`endif
        end
        wr_valid = 1'b0;
        chk("full_empty", 32'(empty), 32'd0);
        chk("full_tx_en", 32'(tx_en), 32'd0);
`ifdef UART_TX_FIFO_OVF_EN
        chk("ovf_after_drop", 32'(ovf), 32'd1);
        wr_valid = 1'b1;
        wr_data  = 8'h99;
        ovf_clr  = 1'b1;
        step();
        chk("ovf_set_wins", 32'(ovf), 32'd1);
        wr_valid = 1'b0;
        step();
        chk("ovf_cleared", 32'(ovf), 32'd0);
        ovf_clr = 1'b0;
`endif
        run_tx(16, 400);
        chk("drain_level", 32'(level), 32'd0);
        chk("drain_ready", 32'(wr_ready), 32'd1);

        // Push and pop in the same cycle at level 5, across pointer wrap.
        busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(8'h40 + i);
            exp_q.push_back(8'(8'h40 + i));
            step();
        end
        wr_valid = 1'b0;
        chk("pp_level_start", 32'(level), 32'd5);
        for (int r = 0; r < 20; r++) begin
            busy     = 1'b0;
            wr_valid = 1'b1;
            wr_data  = 8'(8'h50 + r);
            exp_q.push_back(8'(8'h50 + r));
            step();
            chk($sformatf("pp%0d_tx_en", r), 32'(tx_en), 32'd1);
            chk($sformatf("pp%0d_tx_data", r), 32'(tx_data), 32'(exp_q.pop_front()));
            chk($sformatf("pp%0d_level", r), 32'(level), 32'd5);
            wr_valid = 1'b0;
            step();
            busy = 1'b1;
            step();
            busy = 1'b0;
            step();
        end
        run_tx(5, 200);
        chk("pp_drain_empty", 32'(empty), 32'd1);

        // Reset while waiting on the transmitter with three bytes queued.
        busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(8'hC1 + i);
            step();
        end
        wr_valid = 1'b0;
        busy     = 1'b1;
        step();
        step();
        chk("pre_rst_level", 32'(level), 32'd3);
        chk("pre_rst_tx_data", 32'(tx_data), 32'hC1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_level", 32'(level), 32'd0);
        chk("mid_rst_empty", 32'(empty), 32'd1);
        chk("mid_rst_tx_en", 32'(tx_en), 32'd0);
        chk("mid_rst_tx_data", 32'(tx_data), 32'd0);
        busy = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 8'h5A;
        step();
        wr_valid = 1'b0;
        chk("post_rst_level", 32'(level), 32'd1);
        chk("post_rst_no_early", 32'(tx_en), 32'd0);
        step();
        chk("post_rst_tx_en", 32'(tx_en), 32'd1);
        chk("post_rst_tx_data", 32'(tx_data), 32'h5A);
        chk("post_rst_level0", 32'(level), 32'd0);
        step();
        chk("post_rst_single", 32'(tx_en), 32'd0);
        busy = 1'b1;
        step();
        busy = 1'b0;
        step();
        step();
        chk("post_rst_no_stale", 32'(tx_en), 32'd0);
        chk("post_rst_empty", 32'(empty), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
